// File: rtl/bmem_line_arbiter.sv
// -----------------------------------------------------------------------------
// bmem_line_arbiter
//
// Shares the single banked-burst memory port (bmem_*) between the instruction
// cache (i_*) and the data cache (d_*). Line requests are arbitrated
// round-robin. 256-bit write lines are serialized into 64-bit beats. Returning
// read bursts are deserialized and routed to the matching requester(s) by
// comparing bmem_raddr against the outstanding read addresses.
//
// Optional feature macro: BMEM_ARB_PERF_EN
//   When defined, 32-bit saturating performance counters are added
//   (i_grant_cnt, d_grant_cnt, merge_cnt, stall_cnt, drop_cnt). They are
//   readable hierarchically and have no effect on functional behaviour.
//
// Ports:
//   clk, rst          - single clock; synchronous active-high reset
//   i_addr, i_read    - icache line read request (level-held until i_resp)
//   i_rdata, i_resp   - icache line data and one-cycle completion pulse
//   d_addr, d_read,
//   d_write, d_wdata  - dcache line read/write request (level-held until d_resp)
//   d_rdata, d_resp   - dcache line data and one-cycle completion pulse
//   bmem_addr         - line-aligned command address
//   bmem_read         - read command (held until bmem_ready)
//   bmem_write,
//   bmem_wdata        - write beat valid / data, low beat first
//   bmem_ready        - memory accepts the command or beat this cycle
//   bmem_raddr,
//   bmem_rdata,
//   bmem_rvalid       - returning burst address / beat / beat valid
//
// Handshake: a command or write beat is transferred on a cycle where the
// corresponding bmem_read/bmem_write is high and bmem_ready is high; the
// arbiter holds address and data stable until then. Return beats carry no
// back-pressure: each cycle with bmem_rvalid high delivers one beat, and the
// beats of one burst are contiguous.
// -----------------------------------------------------------------------------
module bmem_line_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CW    = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [31:0]   LINE_MASK = ~(32'(LINE_W / 8) - 32'd1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        WR_BEAT = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       wc;
    logic                cur_d;          // owner of the command in flight: 1 = D
    logic                last_grant_d;   // 1 = D was granted last
    logic                i_pend, d_pend;
    logic                i_out_v, d_out_v;
    logic [31:0]         i_out_addr, d_out_addr;

    logic [CW-1:0]       rc;
    logic [LINE_W-BEAT_W-1:0] asm_buf;   // all beats but the last
    logic [31:0]         cap_addr;

    logic [31:0]         i_line, d_line;
    logic                issuing;
    logic                i_new, i_req, i_merge, i_cand, i_grant;
    logic                d_new, d_req, d_merge, d_cand, d_grant;
    logic                completing, i_hit, d_hit;
    logic                rd_accept, wr_done;
    logic [CW-1:0]       wc_next;
    logic [LINE_W-1:0]   line_now;

    assign i_line  = i_addr & LINE_MASK;
    assign d_line  = d_addr & LINE_MASK;
    assign issuing = (state != IDLE);

    // A request is new only if its owner has nothing pending, in issue,
    // outstanding, or completing this cycle (the request is still held high
    // during the resp cycle).
    assign i_new = i_read & ~(i_pend | i_out_v | (issuing & ~cur_d) | i_resp);
    assign d_new = (d_read | d_write) & ~(d_pend | d_out_v | (issuing & cur_d) | d_resp);
    assign i_req = i_pend | i_new;
    assign d_req = d_pend | d_new;

    // Beat 3 of a burst is arriving: outstanding flags may clear this cycle.
    assign completing = bmem_rvalid & (rc == LAST_BEAT);
    assign i_hit      = completing & i_out_v & (i_out_addr == cap_addr);
    assign d_hit      = completing & d_out_v & (d_out_addr == cap_addr);

    // Merging is suppressed while a burst completes, otherwise the merged
    // requester would wait on a burst that has just finished.
    assign i_merge = i_req & ~completing &
                     ((d_out_v & (d_out_addr == i_line)) |
                      ((state == RD_CMD) & cur_d & (bmem_addr == i_line)));
    assign d_merge = d_req & ~d_write & ~completing &
                     ((i_out_v & (i_out_addr == d_line)) |
                      ((state == RD_CMD) & ~cur_d & (bmem_addr == d_line)));

    // Grants only happen in IDLE, so a read never overtakes a write burst that
    // is still in WR_BEAT to the same line.
    assign i_cand  = i_req & ~i_merge;
    assign d_cand  = d_req & ~d_merge;
    assign i_grant = (state == IDLE) & i_cand & (~d_cand | last_grant_d);
    assign d_grant = (state == IDLE) & d_cand & ~i_grant;

    assign rd_accept = (state == RD_CMD) & bmem_ready;
    assign wr_done   = (state == WR_BEAT) & bmem_ready & (wc == LAST_BEAT);
    assign wc_next   = wc + CW'(1);
    assign line_now  = {bmem_rdata, asm_buf};

    // Issue FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wc           <= '0;
            cur_d        <= 1'b0;
            last_grant_d <= 1'b1;
            i_pend       <= 1'b0;
            d_pend       <= 1'b0;
            bmem_addr    <= '0;
            bmem_read    <= 1'b0;
            bmem_write   <= 1'b0;
            bmem_wdata   <= '0;
        end else begin
            if (i_grant || i_merge)  i_pend <= 1'b0;
            else if (i_new)          i_pend <= 1'b1;
            if (d_grant || d_merge)  d_pend <= 1'b0;
            else if (d_new)          d_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (i_grant) begin
                        state        <= RD_CMD;
                        bmem_read    <= 1'b1;
                        bmem_addr    <= i_line;
                        cur_d        <= 1'b0;
                        last_grant_d <= 1'b0;
                    end else if (d_grant) begin
                        bmem_addr    <= d_line;
                        cur_d        <= 1'b1;
                        last_grant_d <= 1'b1;
                        if (d_write) begin
                            state      <= WR_BEAT;
                            bmem_write <= 1'b1;
                            bmem_wdata <= d_wdata[BEAT_W-1:0];
                            wc         <= '0;
                        end else begin
                            state     <= RD_CMD;
                            bmem_read <= 1'b1;
                        end
                    end
                end
                RD_CMD: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WR_BEAT: begin
                    if (bmem_ready) begin
                        if (wc == LAST_BEAT) begin
                            bmem_write <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            wc         <= wc_next;
                            bmem_wdata <= d_wdata[int'(wc_next)*BEAT_W +: BEAT_W];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outstanding read registers: set on command acceptance or merge,
    // cleared when the matching burst completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_out_v    <= 1'b0;
            d_out_v    <= 1'b0;
            i_out_addr <= '0;
            d_out_addr <= '0;
        end else begin
            if (i_merge) begin
                i_out_v    <= 1'b1;
                i_out_addr <= i_line;
            end else if (rd_accept && !cur_d) begin
                i_out_v    <= 1'b1;
                i_out_addr <= bmem_addr;
            end else if (i_hit) begin
                i_out_v    <= 1'b0;
            end

            if (d_merge) begin
                d_out_v    <= 1'b1;
                d_out_addr <= d_line;
            end else if (rd_accept && cur_d) begin
                d_out_v    <= 1'b1;
                d_out_addr <= bmem_addr;
            end else if (d_hit) begin
                d_out_v    <= 1'b0;
            end
        end
    end

    // Deserializer and response generation
    always_ff @(posedge clk) begin
        if (rst) begin
            rc       <= '0;
            asm_buf  <= '0;
            cap_addr <= '0;
            i_resp   <= 1'b0;
            d_resp   <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            i_resp <= i_hit;
            d_resp <= d_hit | wr_done;
            if (bmem_rvalid) begin
                rc <= rc + CW'(1);
                if (rc == '0)
                    cap_addr <= bmem_raddr & LINE_MASK;
                if (rc != LAST_BEAT)
                    asm_buf[int'(rc)*BEAT_W +: BEAT_W] <= bmem_rdata;
            end
            if (i_hit) i_rdata <= line_now;
            if (d_hit) d_rdata <= line_now;
        end
    end

`ifdef BMEM_ARB_PERF_EN
    logic [31:0] i_grant_cnt, d_grant_cnt, merge_cnt, stall_cnt, drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
            merge_cnt   <= '0;
            stall_cnt   <= '0;
            drop_cnt    <= '0;
        end else begin
            if (i_grant && i_grant_cnt != '1)
                i_grant_cnt <= i_grant_cnt + 32'd1;
            if (d_grant && d_grant_cnt != '1)
                d_grant_cnt <= d_grant_cnt + 32'd1;
            if ((i_merge || d_merge) && merge_cnt != '1)
                merge_cnt <= merge_cnt + 32'd1;
            if (issuing && !bmem_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (completing && !i_hit && !d_hit && drop_cnt != '1)
                drop_cnt <= drop_cnt + 32'd1;
        end
    end
`else
`endif

endmodule
